// File: rtl/fprint_collector_pkg.sv
// Shared register map, field positions and write decode for the fingerprint collector.
package fprint_collector_pkg;

  localparam logic [3:0] FP_CTRL_OFFSET   = 4'h0;
  localparam logic [3:0] FP_CRC_OFFSET    = 4'h4;
  localparam logic [3:0] FP_ERRCLR_OFFSET = 4'h8;

  localparam int FP_ENABLE_BIT = 4;
  localparam int FP_UPPER_BIT  = 5;
  localparam int FP_HALF_MSB   = 31;
  localparam int FP_HALF_LSB   = 16;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_CTRL,
    CMD_CRC,
    CMD_ERRCLR
  } cmd_e;

  // Unknown offsets still complete on the bus but do nothing.
  function automatic cmd_e decode_offset(input logic [3:0] addr);
    case (addr)
      FP_CTRL_OFFSET:   return CMD_CTRL;
      FP_CRC_OFFSET:    return CMD_CRC;
      FP_ERRCLR_OFFSET: return CMD_ERRCLR;
      default:          return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fprint_fifo.sv
// Synchronous FIFO for completed fingerprints, with registered occupancy.
module fprint_fifo
  import fprint_collector_pkg::*;
#(
  parameter int WIDTH = 38,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LEVEL_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level_q;
  logic               do_push;
  logic               do_pop;

  assign full     = (level_q == LEVEL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign level    = level_q;
  assign pop_data = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy; push and pop together leave the level unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/fprint_collector.sv
// Multi-core fingerprint collector: per-core Avalon write slaves, round-robin
// arbitration, lower-half latches and a shared FIFO towards the comparator.
module fprint_collector
  import fprint_collector_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int NUM_TASKS  = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CORE_W  = $clog2(NUM_CORES),
  localparam int TASK_W  = $clog2(NUM_TASKS),
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES*4-1:0]         avs_address,
  input  logic [NUM_CORES-1:0]           avs_write,
  input  logic [NUM_CORES*32-1:0]        avs_writedata,
  output logic [NUM_CORES-1:0]           avs_waitrequest,
  output logic                           fp_valid,
  input  logic                           fp_ready,
  output logic [CORE_W-1:0]              fp_core,
  output logic [TASK_W-1:0]              fp_task,
  output logic [31:0]                    fp_crc,
  output logic                           checkin,
  output logic [CORE_W-1:0]              checkin_core,
  output logic [TASK_W-1:0]              checkin_task,
  output logic [NUM_CORES*NUM_TASKS-1:0] task_en,
  output logic [NUM_CORES-1:0]           err_orphan,
  output logic [LEVEL_W-1:0]             fifo_level
);

  localparam int SLOTS  = NUM_CORES * NUM_TASKS;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int FIFO_W = CORE_W + TASK_W + 32;

  logic [NUM_CORES-1:0] wait_q;
  logic [NUM_CORES-1:0] request;
  logic [CORE_W-1:0]    rr_ptr;
  logic [CORE_W-1:0]    grant_idx;
  logic                 grant_valid;

  logic [3:0]           g_addr;
  logic [31:0]          g_data;
  cmd_e                 g_cmd;
  logic [TASK_W-1:0]    g_task;
  logic                 g_task_ok;
  logic [SLOT_W-1:0]    g_slot;
  logic                 g_upper;
  logic                 g_enable;
  logic [15:0]          g_half;

  logic [SLOTS-1:0]     task_en_q;
  logic [SLOTS-1:0]     lower_vld;
  logic [15:0]          lower_half [SLOTS];
  logic [NUM_CORES-1:0] err_q;
  logic                 checkin_q;
  logic [CORE_W-1:0]    checkin_core_q;
  logic [TASK_W-1:0]    checkin_task_q;

  logic                 push;
  logic                 pop;
  logic [FIFO_W-1:0]    push_data;
  logic [FIFO_W-1:0]    head_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  // A core competes only while its write waits; a full FIFO holds back upper halves only.
  always_comb begin
    request = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      request[c] = avs_write[c] & wait_q[c] &
                   ~(fifo_full &
                     (decode_offset(avs_address[4*c +: 4]) == CMD_CRC) &
                     avs_writedata[32*c + FP_UPPER_BIT]);
    end
  end

  // Round-robin search begins at the core after the most recent grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      if (!grant_valid && request[(int'(rr_ptr) + i) % NUM_CORES]) begin
        grant_valid = 1'b1;
        grant_idx   = CORE_W'((int'(rr_ptr) + i) % NUM_CORES);
      end
    end
  end

  // Field extraction for the write that wins arbitration this cycle.
  always_comb begin
    g_addr    = avs_address[4*int'(grant_idx) +: 4];
    g_data    = avs_writedata[32*int'(grant_idx) +: 32];
    g_cmd     = decode_offset(g_addr);
    g_task    = g_data[TASK_W-1:0];
    g_task_ok = (int'(g_task) < NUM_TASKS);
    g_slot    = SLOT_W'(int'(grant_idx) * NUM_TASKS + int'(g_task));
    g_upper   = g_data[FP_UPPER_BIT];
    g_enable  = g_data[FP_ENABLE_BIT];
    g_half    = g_data[FP_HALF_MSB:FP_HALF_LSB];
  end

  assign push = grant_valid && (g_cmd == CMD_CRC) && g_task_ok && g_upper &&
                task_en_q[g_slot] && lower_vld[g_slot];
  assign push_data = {grant_idx, g_task, g_half, lower_half[g_slot]};
  assign pop = ~fifo_empty & fp_ready;

  // Granted write commits here; its waitrequest drops for the following cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q         <= '1;
      rr_ptr         <= '0;
      task_en_q      <= '0;
      lower_vld      <= '0;
      err_q          <= '0;
      checkin_q      <= 1'b0;
      checkin_core_q <= '0;
      checkin_task_q <= '0;
    end else begin
      wait_q    <= '1;
      checkin_q <= 1'b0;
      if (grant_valid) begin
        wait_q[grant_idx] <= 1'b0;
        rr_ptr            <= grant_idx;
        case (g_cmd)
          CMD_CTRL: begin
            if (g_task_ok) begin
              if (g_enable) begin
                task_en_q[g_slot] <= 1'b1;
              end else begin
                task_en_q[g_slot] <= 1'b0;
                lower_vld[g_slot] <= 1'b0;
                checkin_q         <= 1'b1;
                checkin_core_q    <= grant_idx;
                checkin_task_q    <= g_task;
              end
            end
          end
          CMD_CRC: begin
            if (g_task_ok && task_en_q[g_slot]) begin
              if (!g_upper)               lower_vld[g_slot] <= 1'b1;
              else if (lower_vld[g_slot]) lower_vld[g_slot] <= 1'b0;
              else                        err_q[grant_idx]  <= 1'b1;
            end
          end
          CMD_ERRCLR: err_q[grant_idx] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Lower-half data needs no reset; its valid bit alone says whether it may be used.
  always_ff @(posedge clk) begin
    if (grant_valid && (g_cmd == CMD_CRC) && g_task_ok && !g_upper && task_en_q[g_slot])
      lower_half[g_slot] <= g_half;
  end

  fprint_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign avs_waitrequest           = wait_q;
  assign fp_valid                  = ~fifo_empty;
  assign {fp_core, fp_task, fp_crc} = head_data;
  assign checkin                   = checkin_q;
  assign checkin_core              = checkin_core_q;
  assign checkin_task              = checkin_task_q;
  assign task_en                   = task_en_q;
  assign err_orphan                = err_q;

endmodule
